// File: rtl/divisor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : divisor_pkg                                                |
// | Description : Shared types and constants for the iterative divider:      |
// |               FSM state encoding, sign-mode constants and the helper     |
// |               that sizes the iteration counter from the operand width.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package divisor_pkg;

  // Default operand width of the divider core.
  localparam int WIDTH_PADRAO = 16;

  // Iteration counter width for the default operand width.
  localparam int CONT_W = $clog2(WIDTH_PADRAO);

  // Operating modes selected by modo_sinal.
  localparam logic MODO_SEM_SINAL = 1'b0;
  localparam logic MODO_COM_SINAL = 1'b1;

  // Controller states.
  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    PREPARA = 3'd1,
    ITERA   = 3'd2,
    AJUSTA  = 3'd3,
    FIM     = 3'd4
  } estado_t;

  // Counter width able to hold WIDTH-1 (WIDTH is at least 2).
  function automatic int largura_contador(input int w);
    return $clog2(w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/divisor_passo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : divisor_passo                                              |
// | Description : One combinational restoring-division step. Shifts the      |
// |               {remainder, quotient} pair left by one, trial-subtracts    |
// |               the divisor magnitude and keeps or restores the result.    |
// | Ports       : resto_i     [WIDTH:0]   partial remainder                  |
// |               quoc_i      [WIDTH-1:0] quotient/dividend shift register   |
// |               div_mag_i   [WIDTH-1:0] divisor magnitude                  |
// |               resto_o     [WIDTH:0]   next partial remainder             |
// |               quoc_o      [WIDTH-1:0] next quotient shift register       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module divisor_passo #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   resto_i,
  input  logic [WIDTH-1:0] quoc_i,
  input  logic [WIDTH-1:0] div_mag_i,
  output logic [WIDTH:0]   resto_o,
  output logic [WIDTH-1:0] quoc_o
);

  // One guard bit above the remainder register so the trial difference
  // carries an unambiguous sign bit.
  logic [WIDTH+1:0] w_desloc;
  logic [WIDTH+1:0] w_tentativa;
  logic             w_negativo;

  always_comb begin
    w_desloc    = {resto_i, quoc_i[WIDTH-1]};
    w_tentativa = w_desloc - {2'b00, div_mag_i};
    w_negativo  = w_tentativa[WIDTH+1];
    resto_o     = w_negativo ? w_desloc[WIDTH:0] : w_tentativa[WIDTH:0];
    quoc_o      = {quoc_i[WIDTH-2:0], ~w_negativo};
  end

endmodule
`default_nettype wire

// File: rtl/divisor_iterativo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : divisor_iterativo                                          |
// | Description : Sequential restoring divider, unsigned or two's-complement |
// |               signed, one quotient bit per cycle, start/done handshake   |
// |               and divide-by-zero reporting.                              |
// | Ports       : clk, rst_n (async, active-low)                             |
// |               inicio, modo_sinal, dividendo, divisor  - request inputs   |
// |               pronto        - idle, accepting inicio                     |
// |               valido        - one-cycle pulse on new results             |
// |               saida         - quotient (held)                            |
// |               saida_resto   - remainder (held)                           |
// |               div_zero      - last operation had a zero divisor          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module divisor_iterativo
  import divisor_pkg::*;
#(
  parameter int WIDTH = WIDTH_PADRAO
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inicio,
  input  logic             modo_sinal,
  input  logic [WIDTH-1:0] dividendo,
  input  logic [WIDTH-1:0] divisor,
  output logic             pronto,
  output logic             valido,
  output logic [WIDTH-1:0] saida,
  output logic [WIDTH-1:0] saida_resto,
  output logic             div_zero
);

  localparam int CW = largura_contador(WIDTH);

  estado_t          estado_q,       estado_d;
  logic             modo_q,         modo_d;
  logic [WIDTH-1:0] dividendo_q,    dividendo_d;
  logic [WIDTH-1:0] divisor_q,      divisor_d;
  logic [WIDTH-1:0] div_mag_q,      div_mag_d;
  logic [WIDTH:0]   resto_q,        resto_d;
  logic [WIDTH-1:0] quoc_q,         quoc_d;
  logic [CW-1:0]    cont_q,         cont_d;
  logic             sinal_quoc_q,   sinal_quoc_d;
  logic             sinal_resto_q,  sinal_resto_d;
  logic             zero_q,         zero_d;
  logic [WIDTH-1:0] saida_q,        saida_d;
  logic [WIDTH-1:0] saida_resto_q,  saida_resto_d;
  logic             div_zero_q,     div_zero_d;

  logic [WIDTH:0]   w_resto_prox;
  logic [WIDTH-1:0] w_quoc_prox;
  logic             w_neg_dvd;
  logic             w_neg_dvs;

  divisor_passo #(
    .WIDTH (WIDTH)
  ) u_passo (
    .resto_i   (resto_q),
    .quoc_i    (quoc_q),
    .div_mag_i (div_mag_q),
    .resto_o   (w_resto_prox),
    .quoc_o    (w_quoc_prox)
  );

  // Operand signs only matter in signed mode.
  assign w_neg_dvd = (modo_q == MODO_COM_SINAL) && dividendo_q[WIDTH-1];
  assign w_neg_dvs = (modo_q == MODO_COM_SINAL) && divisor_q[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q      <= OCIOSO;
      modo_q        <= 1'b0;
      dividendo_q   <= '0;
      divisor_q     <= '0;
      div_mag_q     <= '0;
      resto_q       <= '0;
      quoc_q        <= '0;
      cont_q        <= '0;
      sinal_quoc_q  <= 1'b0;
      sinal_resto_q <= 1'b0;
      zero_q        <= 1'b0;
      saida_q       <= '0;
      saida_resto_q <= '0;
      div_zero_q    <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      modo_q        <= modo_d;
      dividendo_q   <= dividendo_d;
      divisor_q     <= divisor_d;
      div_mag_q     <= div_mag_d;
      resto_q       <= resto_d;
      quoc_q        <= quoc_d;
      cont_q        <= cont_d;
      sinal_quoc_q  <= sinal_quoc_d;
      sinal_resto_q <= sinal_resto_d;
      zero_q        <= zero_d;
      saida_q       <= saida_d;
      saida_resto_q <= saida_resto_d;
      div_zero_q    <= div_zero_d;
    end
  end

  always_comb begin
    estado_d      = estado_q;
    modo_d        = modo_q;
    dividendo_d   = dividendo_q;
    divisor_d     = divisor_q;
    div_mag_d     = div_mag_q;
    resto_d       = resto_q;
    quoc_d        = quoc_q;
    cont_d        = cont_q;
    sinal_quoc_d  = sinal_quoc_q;
    sinal_resto_d = sinal_resto_q;
    zero_d        = zero_q;
    saida_d       = saida_q;
    saida_resto_d = saida_resto_q;
    div_zero_d    = div_zero_q;

    unique case (estado_q)
      // FIM also accepts a request so operations can run back to back.
      OCIOSO, FIM: begin
        if (inicio) begin
          modo_d      = modo_sinal;
          dividendo_d = dividendo;
          divisor_d   = divisor;
          estado_d    = PREPARA;
        end else begin
          estado_d    = OCIOSO;
        end
      end

      PREPARA: begin
        zero_d = (divisor_q == '0);
        if (divisor_q == '0) begin
          // Zero divisor skips the iterations; AJUSTA builds the results
          // so they land on the outputs together with valido.
          estado_d = AJUSTA;
        end else begin
          // Negating the most negative value yields 2^(WIDTH-1), which is
          // still correct when read as an unsigned magnitude.
          quoc_d        = w_neg_dvd ? -dividendo_q : dividendo_q;
          div_mag_d     = w_neg_dvs ? -divisor_q   : divisor_q;
          sinal_quoc_d  = w_neg_dvd ^ w_neg_dvs;
          sinal_resto_d = w_neg_dvd;
          resto_d       = '0;
          cont_d        = CW'(WIDTH - 1);
          estado_d      = ITERA;
        end
      end

      ITERA: begin
        resto_d = w_resto_prox;
        quoc_d  = w_quoc_prox;
        cont_d  = cont_q - CW'(1);
        if (cont_q == '0) begin
          estado_d = AJUSTA;
        end
      end

      AJUSTA: begin
        if (zero_q) begin
          saida_d       = '1;
          saida_resto_d = dividendo_q;
          div_zero_d    = 1'b1;
        end else begin
          // Sign flags are clear in unsigned mode, so no mode test here.
          // Truncating negation wraps MIN / -1 back to MIN.
          saida_d       = sinal_quoc_q  ? -quoc_q : quoc_q;
          saida_resto_d = sinal_resto_q ? -resto_q[WIDTH-1:0]
                                        :  resto_q[WIDTH-1:0];
          div_zero_d    = 1'b0;
        end
        estado_d = FIM;
      end

      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  assign pronto      = (estado_q == OCIOSO) || (estado_q == FIM);
  assign valido      = (estado_q == FIM);
  assign saida       = saida_q;
  assign saida_resto = saida_resto_q;
  assign div_zero    = div_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_divisor_iterativo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_divisor_iterativo                                       |
// | Description : Self-checking bench for divisor_iterativo (WIDTH=16) with  |
// |               a reference-model scoreboard of expected results/latency.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_divisor_iterativo;
  import divisor_pkg::*;

  localparam int W        = 16;
  localparam int LAT_NORM = W + 2;
  localparam int LAT_ZERO = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         inicio = 1'b0;
  logic         modo_sinal = 1'b0;
  logic [W-1:0] dividendo = '0;
  logic [W-1:0] divisor = '0;
  logic         pronto;
  logic         valido;
  logic [W-1:0] saida;
  logic [W-1:0] saida_resto;
  logic         div_zero;

  divisor_iterativo #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inicio      (inicio),
    .modo_sinal  (modo_sinal),
    .dividendo   (dividendo),
    .divisor     (divisor),
    .pronto      (pronto),
    .valido      (valido),
    .saida       (saida),
    .saida_resto (saida_resto),
    .div_zero    (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
  } esperado_t;

  esperado_t sb[$];
  int        acc[$];
  int        cyc = 0;
  int        n_checks = 0;
  int        n_err = 0;
  int        n_valido = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic verifica(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: obtido=0x%0h esperado=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: truncating division via the simulator's own arithmetic.
  function automatic esperado_t modelo(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
    esperado_t e;
    longint sa, sbv, q, r;
    if (b == '0) begin
      e.q = '1; e.r = a; e.z = 1'b1; e.lat = LAT_ZERO;
    end else begin
      if (m == MODO_COM_SINAL) begin
        sa = $signed(a); sbv = $signed(b);
      end else begin
        sa = longint'(a); sbv = longint'(b);
      end
      q = sa / sbv;
      r = sa % sbv;
      e.q = q[W-1:0]; e.r = r[W-1:0]; e.z = 1'b0; e.lat = LAT_NORM;
    end
    return e;
  endfunction

  // Output monitor: pops the scoreboard whenever valido is seen.
  always @(negedge clk) begin
    if (rst_n && valido) begin
      esperado_t e;
      int a;
      n_valido++;
      if (sb.size() == 0) begin
        verifica("valido_inesperado", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        a = acc.pop_front();
        verifica("quociente", saida, e.q);
        verifica("resto", saida_resto, e.r);
        verifica("div_zero", div_zero, e.z);
        verifica("latencia", cyc - a, e.lat);
        verifica("pronto_com_valido", pronto, 1'b1);
      end
    end
  end

  // Issue one request; caller is positioned at a negative edge.
  task automatic lanca(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    while (!pronto && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!pronto) verifica("timeout_pronto", 64'd0, 64'd1);
    modo_sinal = m; dividendo = a; divisor = b; inicio = 1'b1;
    sb.push_back(modelo(m, a, b));
    @(posedge clk);
    #1;
    acc.push_back(cyc);
    inicio = 1'b0;
    // Operands may change freely once accepted.
    dividendo = W'($urandom); divisor = W'($urandom); modo_sinal = ~m;
  endtask

  task automatic espera_fim();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      verifica("timeout_valido", 64'd0, 64'd1);
      sb.delete();
      acc.delete();
    end
  endtask

  task automatic opera(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    lanca(m, a, b);
    espera_fim();
  endtask

  initial begin
    int nv;
    int n;
    logic [W-1:0] ra, rb;

    // Reset state
    #2;
    verifica("rst_pronto", pronto, 1'b1);
    verifica("rst_valido", valido, 1'b0);
    verifica("rst_saida", saida, '0);
    verifica("rst_resto", saida_resto, '0);
    verifica("rst_div_zero", div_zero, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    opera(MODO_SEM_SINAL, 16'd100, 16'd7);
    verifica("u100_7_q", saida, 16'd14);
    verifica("u100_7_r", saida_resto, 16'd2);
    opera(MODO_COM_SINAL, 16'hFF9C, 16'd7);
    verifica("s_m100_7_q", saida, 16'hFFF2);
    verifica("s_m100_7_r", saida_resto, 16'hFFFE);
    opera(MODO_COM_SINAL, 16'd100, 16'hFFF9);
    verifica("s_100_m7_q", saida, 16'hFFF2);
    verifica("s_100_m7_r", saida_resto, 16'd2);
    opera(MODO_SEM_SINAL, 16'd5, 16'd0);
    opera(MODO_COM_SINAL, 16'd5, 16'd0);
    verifica("dz_s_q", saida, 16'hFFFF);
    verifica("dz_s_flag", div_zero, 1'b1);
    opera(MODO_COM_SINAL, 16'h8000, 16'hFFFF);
    verifica("ovf_q", saida, 16'h8000);
    verifica("ovf_r", saida_resto, 16'h0000);
    opera(MODO_SEM_SINAL, 16'hFFFF, 16'd1);
    opera(MODO_COM_SINAL, 16'h8000, 16'd1);
    opera(MODO_SEM_SINAL, 16'h8000, 16'hFFFF);
    opera(MODO_COM_SINAL, 16'hFFF9, 16'hFF9C);

    // Random mix in both modes
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = (i % 3 == 0) ? W'($urandom_range(1, 20)) : W'($urandom);
      if (i % 8 == 7) rb = 16'hFFFF;
      opera(logic'(i % 2), ra, rb);
    end

    // Busy inicio ignored; pronto drops after acceptance
    nv = n_valido;
    @(negedge clk);
    lanca(MODO_SEM_SINAL, 16'd1234, 16'd10);
    verifica("pronto_ocupado", pronto, 1'b0);
    repeat (3) @(negedge clk);
    modo_sinal = 1'b1; dividendo = 16'd9; divisor = 16'd0; inicio = 1'b1;
    repeat (2) @(negedge clk);
    inicio = 1'b0;
    espera_fim();
    repeat (25) @(negedge clk);
    verifica("um_valido_apenas", n_valido - nv, 1);

    // Back-to-back: new inicio coincident with valido
    nv = n_valido;
    @(negedge clk);
    lanca(MODO_SEM_SINAL, 16'd500, 16'd3);
    n = 0;
    while (!valido && n < 100) begin
      @(negedge clk);
      n++;
    end
    lanca(MODO_COM_SINAL, 16'hFC18, 16'd9);
    espera_fim();
    verifica("b2b_valido", n_valido - nv, 2);
    verifica("b2b_q", saida, 16'hFF91);

    // Reset mid-operation
    @(negedge clk);
    lanca(MODO_SEM_SINAL, 16'd4321, 16'd3);
    repeat (6) @(negedge clk);
    nv = n_valido;
    rst_n = 1'b0;
    sb.delete();
    acc.delete();
    #1;
    verifica("abort_pronto", pronto, 1'b1);
    verifica("abort_valido", valido, 1'b0);
    verifica("abort_saida", saida, '0);
    verifica("abort_resto", saida_resto, '0);
    verifica("abort_div_zero", div_zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    verifica("abort_sem_valido", n_valido - nv, 0);
    opera(MODO_SEM_SINAL, 16'd1000, 16'd10);
    verifica("pos_reset_q", saida, 16'd100);
    verifica("pos_reset_r", saida_resto, 16'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Absolute time limit as a last-resort guard.
  initial begin
    #2000000;
    $display("FAIL watchdog: obtido=timeout esperado=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
